dac_sample_pacer: RTL and testbench

Sample buffer and pacing stage sitting directly upstream of the DAC pin interface in the PLB DAC peripheral. Software-written 10-bit samples are queued in a small FIFO and released to the DAC data pins at a programmable rate, with a generated data clock whose rising edge falls mid-sample. Underrun and overflow are recorded as sticky flags for the register block to read back.

---
 rtl/dac_sample_pacer.sv | 132 +++++++++++++
 tb/tb_dac_sample_pacer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_pacer.sv
// Sample FIFO and pacing stage feeding the DAC pins: queued samples are released
// one per programmable period, with a data clock whose rising edge falls mid-sample.
module dac_sample_pacer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 10,
    parameter int DIV_W  = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              Bus2IP_Clk,
    input  logic              Bus2IP_Reset,
    input  logic [0:DATA_W-1] Wr_Data,
    input  logic              Wr_En,
    input  logic              Cfg_Enable,
    input  logic [0:DIV_W-1]  Cfg_Div,
    input  logic              Clr_Status,
    output logic              Wr_Full,
    output logic [0:LVL_W-1]  Level,
    output logic              Underrun,
    output logic              Overflow,
    output logic [0:DATA_W-1] DAC_Data,
    output logic              DAC_DCLK
);

    localparam int AW = $clog2(DEPTH);
    // One extra bit so Cfg_Div = all-ones still gives a period of 2^DIV_W + 1.
    localparam int CW = DIV_W + 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic              state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [CW-1:0]     plat, plat_nxt;
    logic              dclk_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] dac_data;
    logic              dclk, underrun, overflow;

    logic              full, empty, wr_accept, load, pop;

    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    // A write at full is dropped even when a pop frees a slot in the same cycle.
    assign wr_accept = Wr_En && !full;
    assign load      = Cfg_Enable && ((state == ST_IDLE) || (cnt == plat - CW'(1)));
    // Pop decision uses the registered level, so a same-cycle write to an
    // empty FIFO cannot bypass straight to the pins.
    assign pop       = load && !empty;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        plat_nxt  = plat;
        if (!Cfg_Enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if (load) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
            plat_nxt  = {1'b0, Cfg_Div} + CW'(2);
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
        dclk_nxt = (state_nxt == ST_RUN) && (cnt_nxt >= (plat_nxt >> 1));
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            plat     <= CW'(2);
            dclk     <= 1'b0;
            dac_data <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            plat  <= plat_nxt;
            dclk  <= dclk_nxt;

            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                dac_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end

            unique case ({wr_accept, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            // Set events take priority over a coincident clear.
            if (load && empty) begin
                underrun <= 1'b1;
            end else if (Clr_Status) begin
                underrun <= 1'b0;
            end
            if (Wr_En && full) begin
                overflow <= 1'b1;
            end else if (Clr_Status) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: sample storage is not reset; emptiness is tracked by the pointers and level.
    always_ff @(posedge Bus2IP_Clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= Wr_Data;
        end
    end

    assign Wr_Full  = full;
    assign Level    = level;
    assign Underrun = underrun;
    assign Overflow = overflow;
    assign DAC_Data = dac_data;
    assign DAC_DCLK = dclk;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Randomized and directed bench for dac_sample_pacer; a queue-based reference
// model predicts pin behaviour and a DCLK-edge monitor scores latched samples.
module tb_dac_sample_pacer;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 10;
    localparam int DIV_W  = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic              en = 1'b0;
    logic              clr = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DIV_W-1:0]  div = '0;

    logic              wr_full, underrun, overflow, dac_dclk;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] dac_data;

    always #5 clk = ~clk;

    dac_sample_pacer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .Wr_Data      (wr_data),
        .Wr_En        (wr_en),
        .Cfg_Enable   (en),
        .Cfg_Div      (div),
        .Clr_Status   (clr),
        .Wr_Full      (wr_full),
        .Level        (level),
        .Underrun     (underrun),
        .Overflow     (overflow),
        .DAC_Data     (dac_data),
        .DAC_DCLK     (dac_dclk)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, pacing as "cycles into current slot".
    logic [DATA_W-1:0] m_fifo[$];
    logic [DATA_W-1:0] exp_latch[$];
    bit                m_run = 0;
    int                m_pos = 0;
    int                m_per = 2;
    logic [DATA_W-1:0] m_data = '0;
    bit                m_dclk = 0;
    bit                m_under = 0;
    bit                m_over = 0;
    bit                chk_en = 0;

    always @(posedge clk) begin
        bit was_full, was_empty, slot, new_dclk;
        if (rst) begin
            m_fifo.delete();
            m_run = 0; m_pos = 0; m_data = '0;
            m_dclk = 0; m_under = 0; m_over = 0;
        end else begin
            was_full  = (m_fifo.size() == DEPTH);
            was_empty = (m_fifo.size() == 0);
            slot      = en && (!m_run || m_pos == m_per - 1);
            if (clr) begin
                m_under = 0;
                m_over  = 0;
            end
            if (wr_en && was_full) m_over = 1;
            if (slot) begin
                if (!was_empty) m_data = m_fifo.pop_front();
                else m_under = 1;
            end
            if (wr_en && !was_full) m_fifo.push_back(wr_data);
            if (!en) begin
                m_run = 0; m_pos = 0;
            end else if (slot) begin
                m_run = 1; m_pos = 0; m_per = int'(div) + 2;
            end else begin
                m_pos++;
            end
            new_dclk = m_run && (m_pos >= m_per / 2);
            if (new_dclk && !m_dclk) exp_latch.push_back(m_data);
            m_dclk = new_dclk;
        end
    end

    // Monitor: the DAC latches on each DCLK rise; compare against the scoreboard.
    always @(posedge dac_dclk) begin
        #1;
        check("dclk_rise_expected", 32'(exp_latch.size() != 0), 32'd1);
        if (exp_latch.size() != 0) check("dac_latch", 32'(dac_data), 32'(exp_latch.pop_front()));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("level",    32'(level),    32'(m_fifo.size()));
            check("wr_full",  32'(wr_full),  32'(m_fifo.size() == DEPTH));
            check("underrun", 32'(underrun), 32'(m_under));
            check("overflow", 32'(overflow), 32'(m_over));
            check("dac_dclk", 32'(dac_dclk), 32'(m_dclk));
            check("dac_data", 32'(dac_data), 32'(m_data));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_data = d;
        cycles(1);
        wr_en = 1'b0;
    endtask

    initial begin
        // Reset held with write and enable asserted: nothing may be accepted.
        rst = 1'b1; wr_en = 1'b1; wr_data = 10'h3ff; en = 1'b1;
        cycles(1);
        chk_en = 1;
        cycles(3);
        rst = 1'b0; wr_en = 1'b0; en = 1'b0;
        cycles(2);

        // Three samples at P = 10, then underrun on the fourth slot.
        for (int i = 1; i <= 3; i++) push(DATA_W'(i));
        div = 16'd8; en = 1'b1;
        cycles(45);
        check("hold_after_underrun", 32'(dac_data), 32'h3);
        en = 1'b0; clr = 1'b1; cycles(1); clr = 1'b0;

        // Overfill, clear, then clear coincident with a full write.
        for (int i = 0; i < DEPTH + 1; i++) push(DATA_W'(10'h100 + i));
        check("full_level", 32'(level), 32'(DEPTH));
        clr = 1'b1; cycles(1);
        wr_en = 1'b1; wr_data = 10'h2aa; cycles(1);
        clr = 1'b0; wr_en = 1'b0;
        check("overflow_kept", 32'(overflow), 32'd1);
        div = 16'd0; en = 1'b1; cycles(40); en = 1'b0; cycles(1);

        // Minimum period with streaming writes.
        div = 16'd0; en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            wr_en = (i % 2 == 0); wr_data = DATA_W'($urandom); cycles(1);
        end
        wr_en = 1'b0; cycles(6); en = 1'b0; cycles(1);

        // Period change mid-slot takes effect at the next boundary.
        for (int i = 0; i < 6; i++) push(DATA_W'($urandom));
        div = 16'd8; en = 1'b1; cycles(4);
        div = 16'd2; cycles(30); en = 1'b0; cycles(1);

        // Abort at cnt = 3, then re-enable.
        for (int i = 0; i < 4; i++) push(DATA_W'($urandom));
        div = 16'd8; en = 1'b1; cycles(4);
        en = 1'b0; cycles(3);
        en = 1'b1; cycles(12); en = 1'b0; cycles(1);

        // Largest divider: DCLK must stay low well past a truncated period.
        push(10'h155); push(10'h0aa);
        div = 16'hffff; en = 1'b1; cycles(300); en = 1'b0; cycles(1);

        // Randomized traffic.
        div = 16'd3; en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wr_en   = $urandom_range(0, 1);
            wr_data = DATA_W'($urandom);
            clr     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) div = DIV_W'($urandom_range(0, 5));
            cycles(1);
        end
        rst = 1'b0; wr_en = 1'b0; clr = 1'b0; en = 1'b0;
        cycles(4);
        check("latch_queue_drained", 32'(exp_latch.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
